ofm_in_fsm: RTL and testbench

Store-and-forward frame writer for the 10GbE transmit path, in the tx_clk domain between the MM2S AXI-Stream source and the transmit data/control FIFO pair. It writes every accepted beat into the data FIFO. After the last beat of a frame it commits one control word (length and status) to the control FIFO. The transmit output stage starts a frame only when a control word is present, so a frame is never started before it is completely buffered.

---
 rtl/ofm_in_fsm_if.sv | 38 +++
 rtl/ofm_in_fsm.sv | 216 +++++++++++++++++++++
 tb/tb_ofm_in_fsm.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ofm_in_fsm_if.sv
// ---------------------------------------------------------------------------
// ofm_in_fsm_if
// AXI-Stream beat channel from the MM2S source into the transmit frame writer.
//
// Signals:
//   s_axis_tdata   64  frame data, byte 0 in [7:0]
//   s_axis_tkeep    8  byte enables
//   s_axis_tvalid   1  source beat valid
//   s_axis_tlast    1  last beat of frame
//   s_axis_tready   1  sink accepts the beat when tvalid && tready
//
// Modports:
//   master : the stream source (drives data/valid/last, observes ready)
//   slave  : the frame writer  (observes data/valid/last, drives ready)
// ---------------------------------------------------------------------------
interface ofm_in_fsm_if;
    logic [63:0] s_axis_tdata;
    logic [7:0]  s_axis_tkeep;
    logic        s_axis_tvalid;
    logic        s_axis_tlast;
    logic        s_axis_tready;

    modport master (
        output s_axis_tdata,
        output s_axis_tkeep,
        output s_axis_tvalid,
        output s_axis_tlast,
        input  s_axis_tready
    );

    modport slave (
        input  s_axis_tdata,
        input  s_axis_tkeep,
        input  s_axis_tvalid,
        input  s_axis_tlast,
        output s_axis_tready
    );
endinterface : ofm_in_fsm_if

// File: rtl/ofm_in_fsm.sv
// ---------------------------------------------------------------------------
// ofm_in_fsm
// Store-and-forward frame writer for the 10GbE transmit path (tx_clk domain).
// Every accepted stream beat is written straight into the data FIFO. Once the
// last beat of a frame has been accepted, a single control word carrying the
// byte count, beat count and runt/oversize flags is committed to the control
// FIFO. The output stage only launches a frame when a control word exists, so
// a frame is never transmitted before it is fully buffered.
//
// Ports:
//   tx_clk           in   1  transmit clock
//   mm2s_resetn      in   1  asynchronous active-low reset
//   s_axis           slave   AXI-Stream beat channel (ofm_in_fsm_if)
//   data_fifo_wdata  out 73  {tlast, tkeep[7:0], tdata[63:0]}
//   data_fifo_wren   out  1  data FIFO write strobe (same cycle as accept)
//   data_fifo_full   in   1  data FIFO full
//   ctrl_fifo_wdata  out 34  {oversize, runt, 3'b0, beat_cnt[12:0], byte_cnt[15:0]}
//   ctrl_fifo_wren   out  1  control FIFO write strobe
//   ctrl_fifo_full   in   1  control FIFO full
//   tx_frame_cnt     out 32  committed frame count, wraps modulo 2^32
//   ofm_in_fsm_dbg   out  4  {1'b0, state[2:0]}
// ---------------------------------------------------------------------------
module ofm_in_fsm #(
    parameter int unsigned C_MIN_BYTES = 14,
    parameter int unsigned C_MAX_BYTES = 9600
) (
    input  logic                tx_clk,
    input  logic                mm2s_resetn,
    ofm_in_fsm_if.slave         s_axis,
    output logic [72:0]         data_fifo_wdata,
    output logic                data_fifo_wren,
    input  logic                data_fifo_full,
    output logic [33:0]         ctrl_fifo_wdata,
    output logic                ctrl_fifo_wren,
    input  logic                ctrl_fifo_full,
    output logic [31:0]         tx_frame_cnt,
    output logic [3:0]          ofm_in_fsm_dbg
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_DATA = 3'd1,
        S_CTRL = 3'd2
    } state_t;

    // Number of valid bytes in a beat.
    function automatic logic [3:0] f_popcount8(input logic [7:0] keep);
        logic [3:0] cnt;
        cnt = 4'd0;
        for (int i = 0; i < 8; i++) begin
            cnt = cnt + {3'd0, keep[i]};
        end
        return cnt;
    endfunction

    // Byte counter add that sticks at all-ones instead of wrapping.
    function automatic logic [15:0] f_sat_add16(input logic [15:0] acc, input logic [3:0] inc);
        logic [16:0] sum;
        sum = {1'b0, acc} + {13'd0, inc};
        if (sum[16]) begin
            return 16'hFFFF;
        end else begin
            return sum[15:0];
        end
    endfunction

    // Beat counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [12:0] f_sat_inc13(input logic [12:0] acc);
        if (acc == 13'h1FFF) begin
            return 13'h1FFF;
        end else begin
            return acc + 13'd1;
        end
    endfunction

    state_t      r_state;
    state_t      w_state_next;
    logic [15:0] r_byte_cnt;
    logic [12:0] r_beat_cnt;
    logic [33:0] r_ctrl_wdata;
    logic [31:0] r_frame_cnt;

    logic        w_tready;
    logic        w_accept;
    logic        w_ctrl_wren;
    logic [15:0] w_byte_next;
    logic [12:0] w_beat_next;
    logic        w_runt;
    logic        w_oversize;
    logic [33:0] w_ctrl_word;

    // Ready per state; forced low while reset is asserted so no beat is taken.
    always_comb begin
        w_tready = 1'b0;
        case (r_state)
            S_IDLE: begin
                // A new frame also needs room for its eventual control word.
                w_tready = ~data_fifo_full & ~ctrl_fifo_full;
            end
            S_DATA: begin
                w_tready = ~data_fifo_full;
            end
            S_CTRL: begin
                w_tready = 1'b0;
            end
            default: begin
                w_tready = 1'b0;
            end
        endcase
        if (!mm2s_resetn) begin
            w_tready = 1'b0;
        end else begin
            w_tready = w_tready;
        end
    end

    assign w_accept = s_axis.s_axis_tvalid & w_tready;

    // Next-state decode and control FIFO strobe.
    always_comb begin
        w_state_next = r_state;
        w_ctrl_wren  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_next = s_axis.s_axis_tlast ? S_CTRL : S_DATA;
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            S_DATA: begin
                if (w_accept && s_axis.s_axis_tlast) begin
                    w_state_next = S_CTRL;
                end else begin
                    w_state_next = S_DATA;
                end
            end
            S_CTRL: begin
                if (!ctrl_fifo_full) begin
                    w_ctrl_wren  = 1'b1;
                    w_state_next = S_IDLE;
                end else begin
                    w_state_next = S_CTRL;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Counts including the beat being accepted this cycle; the control word
    // is built from these so it reflects the final totals on the last beat.
    assign w_byte_next = f_sat_add16(r_byte_cnt, f_popcount8(s_axis.s_axis_tkeep));
    assign w_beat_next = f_sat_inc13(r_beat_cnt);
    assign w_runt      = (32'(w_byte_next) < C_MIN_BYTES);
    assign w_oversize  = (32'(w_byte_next) > C_MAX_BYTES);
    assign w_ctrl_word = {w_oversize, w_runt, 3'b000, w_beat_next, w_byte_next};

    // State register.
    always_ff @(posedge tx_clk or negedge mm2s_resetn) begin
        if (!mm2s_resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Per-frame byte/beat counters; cleared when the control word commits.
    always_ff @(posedge tx_clk or negedge mm2s_resetn) begin
        if (!mm2s_resetn) begin
            r_byte_cnt <= 16'd0;
            r_beat_cnt <= 13'd0;
        end else if (w_accept) begin
            r_byte_cnt <= w_byte_next;
            r_beat_cnt <= w_beat_next;
        end else if (w_ctrl_wren) begin
            r_byte_cnt <= 16'd0;
            r_beat_cnt <= 13'd0;
        end else begin
            r_byte_cnt <= r_byte_cnt;
            r_beat_cnt <= r_beat_cnt;
        end
    end

    // Control word captured on the last-beat accept and held through S_CTRL.
    always_ff @(posedge tx_clk or negedge mm2s_resetn) begin
        if (!mm2s_resetn) begin
            r_ctrl_wdata <= 34'd0;
        end else if (w_accept && s_axis.s_axis_tlast) begin
            r_ctrl_wdata <= w_ctrl_word;
        end else begin
            r_ctrl_wdata <= r_ctrl_wdata;
        end
    end

    // Committed frame counter, free-running modulo 2^32.
    always_ff @(posedge tx_clk or negedge mm2s_resetn) begin
        if (!mm2s_resetn) begin
            r_frame_cnt <= 32'd0;
        end else if (w_ctrl_wren) begin
            r_frame_cnt <= r_frame_cnt + 32'd1;
        end else begin
            r_frame_cnt <= r_frame_cnt;
        end
    end

    assign s_axis.s_axis_tready = w_tready;
    assign data_fifo_wren       = w_accept;
    assign data_fifo_wdata      = {s_axis.s_axis_tlast, s_axis.s_axis_tkeep, s_axis.s_axis_tdata};
    assign ctrl_fifo_wren       = w_ctrl_wren;
    assign ctrl_fifo_wdata      = r_ctrl_wdata;
    assign tx_frame_cnt         = r_frame_cnt;
    assign ofm_in_fsm_dbg       = {1'b0, r_state};

endmodule : ofm_in_fsm

// File: tb/tb_ofm_in_fsm.sv
// ---------------------------------------------------------------------------
// tb_ofm_in_fsm
// Self-checking bench for ofm_in_fsm. A frame-level reference model (running
// byte/beat totals, a "frame open" and a "commit pending" flag) predicts every
// output each cycle. Directed vectors come from a table; long frames, reset
// mid-frame and counter saturation are hand-written; the rest is random.
// ---------------------------------------------------------------------------
module tb_ofm_in_fsm;

    logic        tx_clk = 1'b0;
    logic        mm2s_resetn = 1'b0;
    logic [72:0] dfw_data;
    logic        dfw_en;
    logic        data_fifo_full = 1'b0;
    logic [33:0] cfw_data;
    logic        cfw_en;
    logic        ctrl_fifo_full = 1'b0;
    logic [31:0] frame_cnt;
    logic [3:0]  dbg;

    ofm_in_fsm_if axis ();

    ofm_in_fsm dut (
        .tx_clk          (tx_clk),
        .mm2s_resetn     (mm2s_resetn),
        .s_axis          (axis.slave),
        .data_fifo_wdata (dfw_data),
        .data_fifo_wren  (dfw_en),
        .data_fifo_full  (data_fifo_full),
        .ctrl_fifo_wdata (cfw_data),
        .ctrl_fifo_wren  (cfw_en),
        .ctrl_fifo_full  (ctrl_fifo_full),
        .tx_frame_cnt    (frame_cnt),
        .ofm_in_fsm_dbg  (dbg)
    );

    always #5 tx_clk = ~tx_clk;

    int total = 0;
    int bad   = 0;

    // Reference model state
    bit          m_open;
    bit          m_pend;
    logic [33:0] m_word;
    int          m_bytes;
    int          m_beats;
    logic [31:0] m_frames;
    bit          m_acc;

    // Observations of the DUT strobes
    int          obs_wr;
    int          obs_cw;
    logic [33:0] obs_word;

    function automatic void chk(string name, logic [79:0] act, logic [79:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endfunction

    function automatic logic [33:0] build_word(int bytes, int beats);
        int b;
        int t;
        logic [15:0] b16;
        logic [12:0] t13;
        b   = (bytes > 65535) ? 65535 : bytes;
        t   = (beats > 8191) ? 8191 : beats;
        b16 = b[15:0];
        t13 = t[12:0];
        return {(b > 9600), (b < 14), 3'b000, t13, b16};
    endfunction

    task automatic model_clear();
        m_open = 0; m_pend = 0; m_word = 34'd0; m_bytes = 0; m_beats = 0;
        m_frames = 32'd0; m_acc = 0; obs_wr = 0; obs_cw = 0; obs_word = 34'd0;
    endtask

    task automatic drive(bit v, logic [63:0] d, logic [7:0] k, bit l, bit df, bit cf);
        @(negedge tx_clk);
        axis.s_axis_tvalid = v;
        axis.s_axis_tdata  = d;
        axis.s_axis_tkeep  = k;
        axis.s_axis_tlast  = l;
        data_fifo_full     = df;
        ctrl_fifo_full     = cf;
        #1;
    endtask

    // Compare all outputs against the model, then advance the model by one clock.
    task automatic model_check();
        bit         e_rdy;
        bit         e_cw;
        logic [3:0] e_dbg;
        if (m_pend)      e_rdy = 0;
        else if (m_open) e_rdy = !data_fifo_full;
        else             e_rdy = !data_fifo_full && !ctrl_fifo_full;
        m_acc = axis.s_axis_tvalid && e_rdy;
        e_cw  = m_pend && !ctrl_fifo_full;
        e_dbg = m_pend ? 4'd2 : (m_open ? 4'd1 : 4'd0);
        chk("tready",     80'(axis.s_axis_tready), 80'(e_rdy));
        chk("data_wren",  80'(dfw_en), 80'(m_acc));
        chk("data_wdata", 80'(dfw_data), 80'({axis.s_axis_tlast, axis.s_axis_tkeep, axis.s_axis_tdata}));
        chk("ctrl_wren",  80'(cfw_en), 80'(e_cw));
        if (m_pend) chk("ctrl_wdata", 80'(cfw_data), 80'(m_word));
        chk("frame_cnt",  80'(frame_cnt), 80'(m_frames));
        chk("dbg",        80'(dbg), 80'(e_dbg));
        if (dfw_en) obs_wr++;
        if (cfw_en) begin obs_cw++; obs_word = cfw_data; end
        if (e_cw) begin m_pend = 0; m_frames = m_frames + 32'd1; end
        if (m_acc) begin
            m_bytes += $countones(axis.s_axis_tkeep);
            m_beats += 1;
            if (axis.s_axis_tlast) begin
                m_pend = 1; m_open = 0;
                m_word = build_word(m_bytes, m_beats);
                m_bytes = 0; m_beats = 0;
            end else begin
                m_open = 1;
            end
        end
    endtask

    task automatic step(bit v, logic [63:0] d, logic [7:0] k, bit l, bit df, bit cf);
        drive(v, d, k, l, df, cf);
        model_check();
    endtask

    // Assert reset (with a source trying to send), check reset values, release.
    task automatic do_reset();
        @(negedge tx_clk);
        mm2s_resetn = 1'b0;
        axis.s_axis_tvalid = 1'b1; axis.s_axis_tlast = 1'b0;
        axis.s_axis_tkeep = 8'hFF; axis.s_axis_tdata = 64'd0;
        data_fifo_full = 1'b0; ctrl_fifo_full = 1'b0;
        #1;
        chk("rst_tready",    80'(axis.s_axis_tready), 80'd0);
        chk("rst_data_wren", 80'(dfw_en), 80'd0);
        chk("rst_ctrl_wren", 80'(cfw_en), 80'd0);
        chk("rst_ctrl_word", 80'(cfw_data), 80'd0);
        chk("rst_frame_cnt", 80'(frame_cnt), 80'd0);
        chk("rst_dbg",       80'(dbg), 80'd0);
        model_clear();
        @(negedge tx_clk);
        axis.s_axis_tvalid = 1'b0;
        mm2s_resetn = 1'b1;
    endtask

    typedef struct {
        bit          v;
        logic [63:0] d;
        logic [7:0]  k;
        bit          l, df, cf;
        bit          e_rdy, e_wr, e_cw;
        logic [3:0]  e_dbg;
        logic [33:0] e_word;
        logic [31:0] e_fc;
    } vec_t;

    vec_t tv[$];

    function automatic void add(bit v, logic [63:0] d, logic [7:0] k, bit l, bit df, bit cf,
                                bit e_rdy, bit e_wr, bit e_cw, logic [3:0] e_dbg,
                                logic [33:0] e_word, logic [31:0] e_fc);
        vec_t r;
        r.v = v; r.d = d; r.k = k; r.l = l; r.df = df; r.cf = cf;
        r.e_rdy = e_rdy; r.e_wr = e_wr; r.e_cw = e_cw; r.e_dbg = e_dbg;
        r.e_word = e_word; r.e_fc = e_fc;
        tv.push_back(r);
    endfunction

    initial begin
        int          w0;
        int          len;
        int          guard;
        bit          sent;
        logic [63:0] d;
        logic [7:0]  k;

        axis.s_axis_tvalid = 1'b0; axis.s_axis_tdata = 64'd0;
        axis.s_axis_tkeep = 8'd0; axis.s_axis_tlast = 1'b0;
        model_clear();
        repeat (2) @(negedge tx_clk);
        do_reset();

        // v  data                   keep  l df cf | rdy wr cw dbg word            fcnt
        add(1, 64'h0011223344556677, 8'h3F, 1, 0, 0,  1, 1, 0, 4'd0, 34'd0,           32'd0);
        add(0, 64'd0,                8'h00, 0, 0, 0,  0, 0, 1, 4'd2, 34'h1_0001_0006, 32'd0);
        add(0, 64'd0,                8'h00, 0, 0, 0,  1, 0, 0, 4'd0, 34'd0,           32'd1);
        add(1, 64'hA1A1A1A1A1A1A1A1, 8'h0F, 0, 0, 0,  1, 1, 0, 4'd0, 34'd0,           32'd1);
        add(1, 64'hB2B2B2B2B2B2B2B2, 8'h01, 1, 1, 0,  0, 0, 0, 4'd1, 34'd0,           32'd1);
        add(1, 64'hB2B2B2B2B2B2B2B2, 8'h01, 1, 1, 0,  0, 0, 0, 4'd1, 34'd0,           32'd1);
        add(1, 64'hB2B2B2B2B2B2B2B2, 8'h01, 1, 1, 0,  0, 0, 0, 4'd1, 34'd0,           32'd1);
        add(0, 64'hB2B2B2B2B2B2B2B2, 8'h01, 1, 0, 0,  1, 0, 0, 4'd1, 34'd0,           32'd1);
        add(1, 64'hC3C3C3C3C3C3C3C3, 8'h00, 0, 0, 0,  1, 1, 0, 4'd1, 34'd0,           32'd1);
        add(1, 64'hB2B2B2B2B2B2B2B2, 8'h01, 1, 0, 1,  1, 1, 0, 4'd1, 34'd0,           32'd1);
        add(0, 64'd0,                8'h00, 0, 0, 0,  0, 0, 1, 4'd2, 34'h1_0003_0005, 32'd1);
        add(1, 64'hD4D4D4D4D4D4D4D4, 8'hFF, 1, 0, 1,  0, 0, 0, 4'd0, 34'd0,           32'd2);
        add(1, 64'hD4D4D4D4D4D4D4D4, 8'hFF, 0, 0, 0,  1, 1, 0, 4'd0, 34'd0,           32'd2);
        add(1, 64'hE5E5E5E5E5E5E5E5, 8'hFF, 1, 0, 0,  1, 1, 0, 4'd1, 34'd0,           32'd2);
        for (int i = 0; i < 5; i++)
            add(1, 64'hF6F6F6F6F6F6F6F6, 8'hFF, 0, 0, 1, 0, 0, 0, 4'd2, 34'd0,        32'd2);
        add(1, 64'hF6F6F6F6F6F6F6F6, 8'hFF, 0, 0, 0,  0, 0, 1, 4'd2, 34'h0_0002_0010, 32'd2);
        add(0, 64'd0,                8'h00, 0, 0, 0,  1, 0, 0, 4'd0, 34'd0,           32'd3);

        foreach (tv[i]) begin
            step(tv[i].v, tv[i].d, tv[i].k, tv[i].l, tv[i].df, tv[i].cf);
            chk($sformatf("tv%0d_ready", i), 80'(axis.s_axis_tready), 80'(tv[i].e_rdy));
            chk($sformatf("tv%0d_wren", i),  80'(dfw_en), 80'(tv[i].e_wr));
            chk($sformatf("tv%0d_cwren", i), 80'(cfw_en), 80'(tv[i].e_cw));
            chk($sformatf("tv%0d_dbg", i),   80'(dbg), 80'(tv[i].e_dbg));
            chk($sformatf("tv%0d_fcnt", i),  80'(frame_cnt), 80'(tv[i].e_fc));
            if (tv[i].e_cw) chk($sformatf("tv%0d_word", i), 80'(cfw_data), 80'(tv[i].e_word));
        end

        // 64-byte frame, 8 full beats back to back, then exactly one bubble.
        w0 = obs_wr;
        for (int i = 0; i < 8; i++) step(1, {$urandom, $urandom}, 8'hFF, (i == 7), 0, 0);
        chk("b2b_writes", 80'(obs_wr - w0), 80'd8);
        step(0, 64'd0, 8'h00, 0, 0, 0);
        chk("b2b_bubble_ready", 80'(axis.s_axis_tready), 80'd0);
        chk("b2b_ctrl_wren",    80'(cfw_en), 80'd1);
        chk("b2b_ctrl_word",    80'(cfw_data), 80'(34'h0_0008_0040));
        step(0, 64'd0, 8'h00, 0, 0, 0);
        chk("b2b_ready_again",  80'(axis.s_axis_tready), 80'd1);

        // Oversize frame: 1202 full beats = 9616 bytes.
        w0 = obs_wr;
        for (int i = 0; i < 1202; i++) step(1, {$urandom, $urandom}, 8'hFF, (i == 1201), 0, 0);
        chk("ovs_writes", 80'(obs_wr - w0), 80'd1202);
        step(0, 64'd0, 8'h00, 0, 0, 0);
        chk("ovs_ctrl_wren", 80'(cfw_en), 80'd1);
        chk("ovs_ctrl_word", 80'(cfw_data), 80'(34'h2_04B2_2590));

        // Saturation: 8200 full beats overflow both counters.
        for (int i = 0; i < 8200; i++) step(1, 64'd0, 8'hFF, (i == 8199), 0, 0);
        step(0, 64'd0, 8'h00, 0, 0, 0);
        chk("sat_ctrl_wren", 80'(cfw_en), 80'd1);
        chk("sat_ctrl_word", 80'(cfw_data), 80'(34'h2_1FFF_FFFF));

        // Reset after 3 beats, then a clean 2-beat 16-byte frame.
        for (int i = 0; i < 3; i++) step(1, {$urandom, $urandom}, 8'hFF, 0, 0, 0);
        do_reset();
        step(1, {$urandom, $urandom}, 8'hFF, 0, 0, 0);
        step(1, {$urandom, $urandom}, 8'hFF, 1, 0, 0);
        step(0, 64'd0, 8'h00, 0, 0, 0);
        step(0, 64'd0, 8'h00, 0, 0, 0);
        chk("rstmid_ctrl_count", 80'(obs_cw), 80'd1);
        chk("rstmid_ctrl_word",  80'(obs_word), 80'(34'h0_0002_0010));
        chk("rstmid_frame_cnt",  80'(frame_cnt), 80'd1);

        // Random frames with random valid gaps and FIFO backpressure.
        for (int f = 0; f < 80; f++) begin
            len = $urandom_range(1, 24);
            for (int b = 0; b < len; b++) begin
                d = {$urandom, $urandom};
                k = 8'($urandom);
                if ($urandom_range(0, 3) == 0) k = 8'hFF;
                sent = 0;
                guard = 0;
                while (!sent && guard < 200) begin
                    step(($urandom_range(0, 3) != 0), d, k, (b == len - 1),
                         ($urandom_range(0, 4) == 0), ($urandom_range(0, 4) == 0));
                    sent = axis.s_axis_tvalid && m_acc;
                    guard++;
                end
                if (!sent) chk("rand_beat_timeout", 80'd0, 80'd1);
            end
            repeat ($urandom_range(0, 2)) step(0, 64'd0, 8'h00, 0, ($urandom_range(0, 1) == 0), ($urandom_range(0, 2) == 0));
        end
        guard = 0;
        while (m_pend && guard < 50) begin
            step(0, 64'd0, 8'h00, 0, 0, ($urandom_range(0, 2) == 0));
            guard++;
        end
        if (m_pend) chk("rand_drain_timeout", 80'd0, 80'd1);
        chk("rand_frame_cnt", 80'(frame_cnt), 80'(32'd81));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_ofm_in_fsm
